// File: rtl/avalon_burst_sched.sv
// Avalon burst scheduler: splits a byte transfer into master commands of at
// most MAX_CHUNK bytes, issuing one command at a time and waiting for the
// master to return idle before issuing the next.
module avalon_burst_sched #(
  parameter int unsigned XAW       = 32,
  parameter int unsigned CW        = 8,
  parameter int unsigned MAX_CHUNK = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [XAW-1:0] base_addr,
  input  logic [XAW-1:0] total_len,
  output logic           mst_go,
  output logic [XAW-1:0] mst_base,
  output logic [CW-1:0]  mst_length,
  output logic           mst_fixed_location,
  input  logic           mst_done,
  output logic           busy,
  output logic           xfer_done,
  output logic [XAW-5:0] chunk_cnt
);

  localparam int unsigned    CNTW        = XAW - 4;
  localparam logic [XAW-1:0] LEN_MASK    = {{(XAW-4){1'b1}}, 4'b0000};
  localparam logic [XAW-1:0] MAX_CHUNK_X = XAW'(MAX_CHUNK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [XAW-1:0]  cur_addr_q, cur_addr_d;
  logic [XAW-1:0]  rem_q, rem_d;
  logic            mst_go_q, mst_go_d;
  logic [XAW-1:0]  mst_base_q, mst_base_d;
  logic [CW-1:0]   mst_length_q, mst_length_d;
  logic            busy_q, busy_d;
  logic            xfer_done_q, xfer_done_d;
  logic [CNTW-1:0] chunk_cnt_q, chunk_cnt_d;

  logic [XAW-1:0]  len_masked;
  logic [XAW-1:0]  rem_upd;
  logic [XAW-1:0]  addr_upd;

  // Size of the next command: the remaining bytes, capped at MAX_CHUNK.
  function automatic logic [CW-1:0] chunk_of(input logic [XAW-1:0] r);
    chunk_of = (r < MAX_CHUNK_X) ? CW'(r) : CW'(MAX_CHUNK);
  endfunction

  // Transfer bookkeeping; the live command length doubles as the chunk size.
  always_comb begin
    len_masked = total_len & LEN_MASK;
    rem_upd    = rem_q - XAW'(mst_length_q);
    addr_upd   = cur_addr_q + XAW'(mst_length_q);
  end

  // Next-state and registered-output decode; command outputs are loaded on
  // the transition into ISSUE so mst_go lines up with the ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    mst_go_d     = 1'b0;
    mst_base_d   = mst_base_q;
    mst_length_d = mst_length_q;
    busy_d       = busy_q;
    xfer_done_d  = 1'b0;
    chunk_cnt_d  = chunk_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          cur_addr_d  = base_addr;
          rem_d       = len_masked;
          busy_d      = 1'b1;
          chunk_cnt_d = '0;
          if (len_masked == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d      = S_ISSUE;
            mst_go_d     = 1'b1;
            mst_base_d   = base_addr;
            mst_length_d = chunk_of(len_masked);
            chunk_cnt_d  = CNTW'(1);
          end
        end
      end

      S_ISSUE: state_d = S_GUARD;

      // The master still reports idle in the cycle after go; skip it.
      S_GUARD: state_d = S_WAIT;

      S_WAIT: begin
        if (mst_done) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        cur_addr_d = addr_upd;
        rem_d      = rem_upd;
        if (rem_upd != '0) begin
          state_d      = S_ISSUE;
          mst_go_d     = 1'b1;
          mst_base_d   = addr_upd;
          mst_length_d = chunk_of(rem_upd);
          chunk_cnt_d  = chunk_cnt_q + CNTW'(1);
        end else begin
          state_d = S_FINISH;
        end
      end

      // busy drops together with the end of the xfer_done pulse.
      S_FINISH: begin
        xfer_done_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      mst_go_q     <= 1'b0;
      mst_base_q   <= '0;
      mst_length_q <= '0;
      busy_q       <= 1'b0;
      xfer_done_q  <= 1'b0;
      chunk_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      rem_q        <= rem_d;
      mst_go_q     <= mst_go_d;
      mst_base_q   <= mst_base_d;
      mst_length_q <= mst_length_d;
      busy_q       <= busy_d;
      xfer_done_q  <= xfer_done_d;
      chunk_cnt_q  <= chunk_cnt_d;
    end
  end

  assign mst_go             = mst_go_q;
  assign mst_base           = mst_base_q;
  assign mst_length         = mst_length_q;
  assign mst_fixed_location = 1'b0;
  assign busy               = busy_q;
  assign xfer_done          = xfer_done_q;
  assign chunk_cnt          = chunk_cnt_q;

endmodule

// File: doc/avalon_burst_sched.md
AVALON_BURST_SCHED -- requirements
Module: avalon_burst_sched

Interface
REQ-001 Parameter XAW, default 32: external address and length width, in bytes.
REQ-002 Parameter CW, default 8: width of the master length field.
REQ-003 Parameter MAX_CHUNK, default 128: maximum bytes per master command; SHALL be a multiple of 16 and at most 2^CW-1.
REQ-004 clk  input  1: single clock; all logic is on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 start  input  1: one-cycle request to begin a transfer.
REQ-007 base_addr  input  XAW: transfer byte start address, sampled on an accepted start.
REQ-008 total_len  input  XAW: transfer byte count, sampled on an accepted start.
REQ-009 mst_go  output  1: one-cycle command strobe to the read/write master control port.
REQ-010 mst_base  output  XAW: byte address of the current command.
REQ-011 mst_length  output  CW: byte length of the current command.
REQ-012 mst_fixed_location  output  1: tied 0.
REQ-013 mst_done  input  1: master idle/complete level; high when the master is idle.
REQ-014 busy  output  1: high from an accepted start until xfer_done.
REQ-015 xfer_done  output  1: one-cycle pulse at transfer completion.
REQ-016 chunk_cnt  output  XAW-4: number of commands issued in the current transfer.

Function
REQ-017 The block SHALL have states IDLE, ISSUE, GUARD, WAIT, NEXT and FINISH.
REQ-018 In IDLE with start=1, the block SHALL latch base_addr into cur_addr and total_len with bits [3:0] cleared into rem, set busy, and go to ISSUE, or to FINISH if the masked length is 0.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 On entry to ISSUE, the block SHALL set chunk = min(rem, MAX_CHUNK) and drive mst_base=cur_addr and mst_length=chunk.
REQ-021 mst_go SHALL be high for exactly the one ISSUE cycle; chunk_cnt SHALL increment in that same cycle; next state is GUARD.
REQ-022 GUARD SHALL last exactly one cycle and SHALL ignore mst_done, masking the stale idle level the master shows in the cycle after go; next state is WAIT.
REQ-023 WAIT SHALL hold until mst_done=1 is sampled, then go to NEXT.
REQ-024 mst_base and mst_length SHALL stay stable from ISSUE through the end of WAIT.
REQ-025 In NEXT, the block SHALL update cur_addr += chunk and rem -= chunk, then go to ISSUE if rem != 0 after the update, else to FINISH.
REQ-026 FINISH SHALL pulse xfer_done for one cycle, clear busy in the same cycle, and return to IDLE.
REQ-027 Latency per chunk SHALL be 4 cycles plus master time: ISSUE, GUARD, WAIT (one cycle minimum), NEXT.
REQ-028 The first mst_go SHALL assert in the cycle after start is sampled.
REQ-029 A zero-length transfer SHALL pulse xfer_done 2 cycles after start is sampled, with no mst_go.
REQ-030 All arithmetic SHALL be unsigned at XAW bits; address wrap past 2^XAW-1 SHALL wrap modulo 2^XAW without error.
REQ-031 chunk_cnt SHALL clear on an accepted start and hold its value after xfer_done until the next accepted start.

Reset
REQ-032 With rst=1 at a clock edge, state SHALL be IDLE, and mst_go, busy, xfer_done, mst_base, mst_length, chunk_cnt, cur_addr and rem SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer: no further mst_go and no xfer_done for it; a start after reset releases SHALL be accepted normally.
REQ-034 start coincident with rst=1 SHALL be ignored.

Verification
REQ-035 Bench: base_addr=0x1000, total_len=1024, master done after 5 cycles -> exactly 8 mst_go pulses, mst_base 0x1000, 0x1080 .. 0x1380, mst_length=128 each, chunk_cnt=8, one xfer_done.
REQ-036 Bench: total_len=208 -> 2 commands, lengths 128 then 80, bases base and base+128; total_len=215 behaves identically because bits [3:0] are masked.
REQ-037 Bench: total_len=0 -> no mst_go, xfer_done 2 cycles after start, busy high for exactly 2 cycles.
REQ-038 Bench: mst_done held at 1 continuously -> each chunk takes exactly 4 cycles, and GUARD prevents any early completion.
REQ-039 Bench: second start pulse mid-transfer with different base_addr -> ignored; first transfer's addresses continue unchanged.
REQ-040 Bench: rst pulsed during the WAIT of chunk 3 of 8 -> all outputs 0 in the next cycle, no xfer_done; a fresh start then completes a full 8-chunk transfer.
